// File: rtl/scc_pkg.sv
// Shared constants and types for the SCC tone-generator output path.
package scc_pkg;
  localparam int unsigned SCC_CH_NUM    = 5;
  localparam logic [2:0]  SCC_SLOT_IDLE = 3'd5;
  localparam int unsigned SCC_SAMPLE_W  = 8;
  localparam int unsigned SCC_VOL_W     = 4;
  localparam int unsigned SCC_OUT_W     = 15;
  localparam int unsigned SCC_PROD_W    = SCC_SAMPLE_W + SCC_VOL_W;

  typedef logic signed [SCC_PROD_W-1:0] scc_product_t;
endpackage

// File: rtl/scc_volume_multiplier.sv
// Registered signed-sample by unsigned-volume multiply with an enable gate;
// carries the channel tag alongside the product.
module scc_volume_multiplier #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned VOL_W    = 4,
  parameter int unsigned PROD_W   = SAMPLE_W + VOL_W
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       en,
  input  logic [2:0]                 tag_in,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic [VOL_W-1:0]           volume,
  output logic signed [PROD_W-1:0]   product,
  output logic [2:0]                 tag_out
);

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] volume_ext;

  // Volume is unsigned: a zero MSB keeps it non-negative in the signed product.
  assign sample_ext = PROD_W'(sample);
  assign volume_ext = PROD_W'($signed({1'b0, volume}));

  always_ff @(posedge clk) begin
    if (!nreset) begin
      product <= '0;
      tag_out <= '0;
    end else begin
      product <= en ? sample_ext * volume_ext : '0;
      tag_out <= tag_in;
    end
  end

endmodule

// File: rtl/scc_channel_mixer.sv
// Scales each slot's wave-RAM sample by its channel volume and sums the five
// channels into one signed mixed sample per 6-slot frame.
module scc_channel_mixer
  import scc_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SCC_SAMPLE_W,
  parameter int unsigned VOL_W    = SCC_VOL_W,
  parameter int unsigned OUT_W    = SCC_OUT_W
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [2:0]                 active,
  input  logic signed [SAMPLE_W-1:0] wave_data,
  input  logic [VOL_W-1:0]           reg_volume_a,
  input  logic [VOL_W-1:0]           reg_volume_b,
  input  logic [VOL_W-1:0]           reg_volume_c,
  input  logic [VOL_W-1:0]           reg_volume_d,
  input  logic [VOL_W-1:0]           reg_volume_e,
  input  logic [SCC_CH_NUM-1:0]      reg_enable,
  output logic signed [OUT_W-1:0]    mixed_out,
  output logic                       mixed_valid
);

  localparam int unsigned PROD_W = SAMPLE_W + VOL_W;

  logic [2:0]               ff_active_d1;
  logic [VOL_W-1:0]         vol_sel;
  logic                     ch_ok;
  logic signed [PROD_W-1:0] ff_product;
  logic [2:0]               ff_product_ch;
  logic signed [OUT_W-1:0]  ff_acc;
  logic signed [OUT_W-1:0]  product_ext;
  logic signed [OUT_W-1:0]  acc_sum;

  // Wave RAM answers one cycle late, so the data belongs to the delayed slot.
  always_ff @(posedge clk) begin
    if (!nreset) ff_active_d1 <= '0;
    else         ff_active_d1 <= active;
  end

  always_comb begin
    vol_sel = '0;
    ch_ok   = 1'b0;
    if (ff_active_d1 < SCC_SLOT_IDLE) ch_ok = reg_enable[ff_active_d1];
    case (ff_active_d1)
      3'd0:    vol_sel = reg_volume_a;
      3'd1:    vol_sel = reg_volume_b;
      3'd2:    vol_sel = reg_volume_c;
      3'd3:    vol_sel = reg_volume_d;
      3'd4:    vol_sel = reg_volume_e;
      default: vol_sel = '0;
    endcase
  end

  scc_volume_multiplier #(
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W),
    .PROD_W   (PROD_W)
  ) u_mult (
    .clk     (clk),
    .nreset  (nreset),
    .en      (ch_ok),
    .tag_in  (ff_active_d1),
    .sample  (wave_data),
    .volume  (vol_sel),
    .product (ff_product),
    .tag_out (ff_product_ch)
  );

  assign product_ext = OUT_W'(ff_product);
  assign acc_sum     = ff_acc + product_ext;

  // Channel a restarts the frame sum; channel e publishes it.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      ff_acc      <= '0;
      mixed_out   <= '0;
      mixed_valid <= 1'b0;
    end else begin
      mixed_valid <= 1'b0;
      case (ff_product_ch)
        3'd0:             ff_acc <= product_ext;
        3'd1, 3'd2, 3'd3: ff_acc <= acc_sum;
        3'd4: begin
          mixed_out   <= acc_sum;
          mixed_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scc_channel_mixer.sv
// Randomized and directed checks of scc_channel_mixer against a slot-level model.
module tb_scc_channel_mixer;
  import scc_pkg::*;

  logic                    clk;
  logic                    nreset;
  logic [2:0]              active;
  logic signed [7:0]       wave_data;
  logic [3:0]              vol_a, vol_b, vol_c, vol_d, vol_e;
  logic [4:0]              reg_enable;
  logic signed [SCC_OUT_W-1:0] mixed_out;
  logic                    mixed_valid;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // stimulus controls
  int                slot      = 5;
  int                wave_mode = 0;
  logic signed [7:0] wave_const = 8'sd0;
  bit                inj       = 1'b0;
  bit                rand_bad  = 1'b0;

  scc_channel_mixer dut (
    .clk          (clk),
    .nreset       (nreset),
    .active       (active),
    .wave_data    (wave_data),
    .reg_volume_a (vol_a),
    .reg_volume_b (vol_b),
    .reg_volume_c (vol_c),
    .reg_volume_d (vol_d),
    .reg_volume_e (vol_e),
    .reg_enable   (reg_enable),
    .mixed_out    (mixed_out),
    .mixed_valid  (mixed_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int vol_of(input int ch);
    case (ch)
      0: return int'(vol_a);
      1: return int'(vol_b);
      2: return int'(vol_c);
      3: return int'(vol_d);
      4: return int'(vol_e);
      default: return 0;
    endcase
  endfunction

  // Model: each slot's data is credited to the channel addressed one slot earlier;
  // that contribution joins the frame sum one slot after it is formed.
  int m_prev_ch, m_pend_ch, m_pend_val, m_acc, m_out;
  bit m_valid;
  initial begin
    m_prev_ch = 0; m_pend_ch = 0; m_pend_val = 0; m_acc = 0; m_out = 0; m_valid = 0;
  end

  always @(posedge clk) begin
    int contrib;
    if (!nreset) begin
      m_prev_ch = 0; m_pend_ch = 0; m_pend_val = 0; m_acc = 0; m_out = 0; m_valid = 0;
    end else begin
      contrib = 0;
      if (m_prev_ch < 5 && reg_enable[m_prev_ch])
        contrib = int'(wave_data) * vol_of(m_prev_ch);
      m_valid = 1'b0;
      if (m_pend_ch == 0) m_acc = m_pend_val;
      else if (m_pend_ch <= 3) m_acc = m_acc + m_pend_val;
      else if (m_pend_ch == 4) begin
        m_out   = m_acc + m_pend_val;
        m_valid = 1'b1;
      end
      m_pend_ch  = m_prev_ch;
      m_pend_val = contrib;
      m_prev_ch  = int'(active);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    tests++;
    if (int'(mixed_out) != m_out || mixed_valid !== m_valid) begin
      fails++;
      $display("FAIL model cyc=%0d: out=%0d valid=%0b, required out=%0d valid=%0b",
               cyc, mixed_out, mixed_valid, m_out, m_valid);
    end
  end

  task automatic check_eq(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mixed_valid === 1'b1) return;
    end
    tests++;
    fails++;
    $display("FAIL %s: no mixed_valid within 12 cycles", name);
  endtask

  task automatic set_vols(input logic [3:0] a, b, c, d, e);
    vol_a = a; vol_b = b; vol_c = c; vol_d = d; vol_e = e;
  endtask

  // Slot sequencer and wave-RAM emulation.
  task automatic drive_slots();
    int a;
    forever begin
      @(posedge clk);
      #1;
      slot = (slot == 5) ? 0 : slot + 1;
      a = slot;
      if (inj && slot == 3) a = 6;
      if (inj && slot == 5) begin a = 7; inj = 1'b0; end
      if (rand_bad && $urandom_range(0, 15) == 0) a = 6 + $urandom_range(0, 1);
      active = 3'(a);
      case (wave_mode)
        0: wave_data = wave_const;
        1: wave_data = 8'($urandom);
        default: wave_data = (slot == 2) ? -8'sd5 : 8'($urandom);
      endcase
    end
  endtask

  initial begin
    int t0;
    nreset = 1'b0; active = 3'd0; wave_data = 8'sd0;
    set_vols(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    reg_enable = 5'h00;
    fork drive_slots(); join_none

    // Reset held with the slot sequence running.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("reset_out", int'(mixed_out), 0);
      check_eq("reset_valid", int'(mixed_valid), 0);
    end
    nreset = 1'b1;

    // Full-scale positive.
    set_vols(4'd15, 4'd15, 4'd15, 4'd15, 4'd15);
    reg_enable = 5'h1F; wave_mode = 0; wave_const = 8'sd127;
    wait_valid("pos_a"); wait_valid("pos_b");
    check_eq("pos_full", int'(mixed_out), 9525);
    t0 = cyc;
    wait_valid("pos_c");
    check_eq("pos_period", cyc - t0, 6);
    check_eq("pos_slot", int'(active), 1);

    // Full-scale negative.
    wave_const = -8'sd128;
    wait_valid("neg_a"); wait_valid("neg_b");
    check_eq("neg_full", int'(mixed_out), -9600);
    tests++;
    if (mixed_out !== 15'h5A80) begin
      fails++;
      $display("FAIL neg_bits: got %h, required 5a80", mixed_out);
    end

    // Single channel b.
    set_vols(4'd0, 4'd3, 4'd0, 4'd0, 4'd0);
    wave_mode = 2;
    wait_valid("b_a"); wait_valid("b_b");
    check_eq("only_b", int'(mixed_out), -15);

    // Enable mask.
    set_vols(4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
    reg_enable = 5'b10101; wave_mode = 0; wave_const = 8'sd10;
    wait_valid("en_a"); wait_valid("en_b");
    check_eq("en_10101", int'(mixed_out), 30);
    reg_enable = 5'h00;
    wait_valid("dis_a"); wait_valid("dis_b");
    check_eq("en_none", int'(mixed_out), 0);

    // Mid-frame reset after ch b's data slot.
    reg_enable = 5'b11110;
    wait_valid("mr_a"); wait_valid("mr_b");
    check_eq("pre_reset", int'(mixed_out), 40);
    while (active !== 3'd2) @(negedge clk);
    @(posedge clk); #1 nreset = 1'b0;
    @(posedge clk); #1 nreset = 1'b1;
    wait_valid("mr_c");
    check_eq("post_reset", int'(mixed_out), 10);

    // Invalid slot codes replace ch d and idle for one frame.
    reg_enable = 5'h1F;
    wait_valid("bad_a"); wait_valid("bad_b");
    check_eq("all_on", int'(mixed_out), 50);
    inj = 1'b1;
    wait_valid("bad_c");
    check_eq("invalid_slot", int'(mixed_out), 40);
    wait_valid("bad_d");
    check_eq("after_invalid", int'(mixed_out), 50);

    // Random phase: random data, config, invalid slots and one reset.
    wave_mode = 1; rand_bad = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)
        set_vols(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 9) == 0) reg_enable = 5'($urandom);
      if (i == 200) nreset = 1'b0;
      if (i == 201) nreset = 1'b1;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
